// File: rtl/snes_poll_sequencer_if.sv
// Bus-side bundle between the register file and the SNES poll sequencer.
// Signals: enable, poll_req (to sequencer); busy, buttons, buttons_valid, changed (from it).
interface snes_poll_sequencer_if;
    logic        enable;
    logic        poll_req;
    logic        busy;
    logic [15:0] buttons;
    logic        buttons_valid;
    logic        changed;

    modport master (
        output enable,
        output poll_req,
        input  busy,
        input  buttons,
        input  buttons_valid,
        input  changed
    );

    modport slave (
        input  enable,
        input  poll_req,
        output busy,
        output buttons,
        output buttons_valid,
        output changed
    );
endinterface

// File: rtl/snes_poll_sequencer.sv
// SNES controller poll sequencer: drives latch/clock pins, shifts in 16 bits,
// publishes an active-high button word with a valid strobe and sticky changed flag.
// Ports: ACLK, ARESETN (async active-low), bus (slave: enable, poll_req, busy,
// buttons, buttons_valid, changed), snes_data (in, active-low), snes_latch, snes_clk.
// Optional: define SNES_AUTOPOLL_EN for a periodic poll timer of POLL_CYCLES.
module snes_poll_sequencer #(
    parameter int unsigned HALF_CYCLES = 600,
    parameter int unsigned POLL_CYCLES = 1666666
) (
    input  logic                        ACLK,
    input  logic                        ARESETN,
    snes_poll_sequencer_if.slave        bus,
    input  logic                        snes_data,
    output logic                        snes_latch,
    output logic                        snes_clk
);

    localparam int unsigned PH_W = $clog2(2 * HALF_CYCLES);
    localparam logic [PH_W-1:0] LATCH_END = PH_W'(2 * HALF_CYCLES - 1);
    localparam logic [PH_W-1:0] HALF_END  = PH_W'(HALF_CYCLES - 1);

    if (HALF_CYCLES < 2) begin : g_bad_half
        $error("HALF_CYCLES must be at least 2");
    end
    if (POLL_CYCLES <= 34 * HALF_CYCLES) begin : g_bad_poll
        $error("POLL_CYCLES must exceed 34*HALF_CYCLES");
    end

    typedef enum logic [2:0] {
        IDLE,
        LATCH,
        CLK_LO,
        CLK_HI,
        DONE
    } state_t;

    state_t          state_q;
    state_t          state_d;
    logic [PH_W-1:0] phase_q;
    logic [3:0]      bit_q;
    logic [15:0]     shreg_q;
    logic            phase_end;
    logic            last_bit;
    logic            start;
    logic            done_enter;
    logic            autopoll_pending;

    // ---------------------------------------------------------------
    // Optional periodic poll timer
    // ---------------------------------------------------------------
`ifdef SNES_AUTOPOLL_EN
    localparam int unsigned TMR_W = $clog2(POLL_CYCLES);
    localparam logic [TMR_W-1:0] TMR_RELOAD = TMR_W'(POLL_CYCLES - 1);

    logic [TMR_W-1:0] tmr_q;
    logic             pend_q;

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            tmr_q  <= '0;
            pend_q <= 1'b0;
        end else if (!bus.enable) begin
            tmr_q  <= TMR_RELOAD;
            pend_q <= 1'b0;
        end else begin
            tmr_q <= (tmr_q == '0) ? TMR_RELOAD : tmr_q - TMR_W'(1);
            // A start absorbs an expiry landing on the same cycle, so a
            // coincident poll_req and expiry yield a single transaction.
            if (start) begin
                pend_q <= 1'b0;
            end else if (tmr_q == '0) begin
                pend_q <= 1'b1;
            end
        end
    end

    assign autopoll_pending = pend_q;
`else
    assign autopoll_pending = 1'b0;
`endif

    // ---------------------------------------------------------------
    // Phase decode
    // ---------------------------------------------------------------
    always_comb begin
        phase_end = 1'b0;
        unique case (state_q)
            LATCH:          phase_end = (phase_q == LATCH_END);
            CLK_LO, CLK_HI: phase_end = (phase_q == HALF_END);
            default:        phase_end = 1'b0;
        endcase
    end

    assign last_bit   = (bit_q == 4'd15);
    assign start      = (state_q == IDLE) & bus.enable
                      & (bus.poll_req | autopoll_pending);
    assign done_enter = (state_q == CLK_HI) & phase_end & last_bit;

    // ---------------------------------------------------------------
    // FSM: state register
    // ---------------------------------------------------------------
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------------------------------------------------------
    // FSM: next state
    // ---------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (start) state_d = LATCH;
            end
            LATCH: begin
                if (phase_end) state_d = CLK_LO;
            end
            CLK_LO: begin
                if (phase_end) state_d = CLK_HI;
            end
            CLK_HI: begin
                if (phase_end) state_d = last_bit ? DONE : CLK_LO;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // ---------------------------------------------------------------
    // FSM: outputs (pure decode of the state register, so an async
    // reset returns the pins to idle levels immediately)
    // ---------------------------------------------------------------
    always_comb begin
        snes_latch = 1'b0;
        snes_clk   = 1'b1;
        bus.busy   = 1'b1;
        unique case (state_q)
            IDLE:    bus.busy   = 1'b0;
            LATCH:   snes_latch = 1'b1;
            CLK_LO:  snes_clk   = 1'b0;
            default: ;
        endcase
    end

    // ---------------------------------------------------------------
    // Phase counter, bit index and shift register
    // ---------------------------------------------------------------
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            phase_q <= '0;
            bit_q   <= 4'd0;
            shreg_q <= 16'h0000;
        end else begin
            if (state_q == IDLE || state_q == DONE || phase_end) begin
                phase_q <= '0;
            end else begin
                phase_q <= phase_q + PH_W'(1);
            end

            if (start) begin
                shreg_q <= 16'h0000;
            end

            if (state_q == LATCH && phase_end) begin
                bit_q <= 4'd0;
            end

            // Last cycle of the low phase: the pad shifted on the previous
            // rising edge, so its data has been stable for a whole high phase.
            if (state_q == CLK_LO && phase_end) begin
                shreg_q[bit_q] <= ~snes_data;
            end

            if (state_q == CLK_HI && phase_end && !last_bit) begin
                bit_q <= bit_q + 4'd1;
            end
        end
    end

    // ---------------------------------------------------------------
    // Published word, strobe and sticky change flag
    // ---------------------------------------------------------------
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            bus.buttons       <= 16'h0000;
            bus.buttons_valid <= 1'b0;
            bus.changed       <= 1'b0;
        end else begin
            bus.buttons_valid <= done_enter;
            if (done_enter) begin
                bus.buttons <= shreg_q;
            end
            // Set has priority over the poll_req clear.
            if (done_enter && (shreg_q != bus.buttons)) begin
                bus.changed <= 1'b1;
            end else if (bus.poll_req) begin
                bus.changed <= 1'b0;
            end
        end
    end

endmodule
